alu_pipe: RTL

Parametrised, registered ALU with a valid/ready input handshake and an iterative shift-add multiplier. Successor to the single-cycle 32-bit ALU: width is a parameter, results and flags are registered, and a multi-cycle MUL opcode is added with backpressure. Sits between operand fetch and writeback in the datapath. All single-cycle ops complete in one clock; MUL holds the input closed for WIDTH cycles.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_if.sv | 28 ++
 rtl/alu_mul_seq.sv | 50 +++++
 rtl/alu_pipe.sv | 130 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_pkg : opcodes, status bit indices, FSM states for alu_pipe
// Revision 1.0
// ------------------------------------------------------------------
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SUB = 6'b010001;
  localparam logic [5:0] OP_SLT = 6'b010010;
  localparam logic [5:0] OP_AND = 6'b001100;
  localparam logic [5:0] OP_OR  = 6'b001101;
  localparam logic [5:0] OP_XOR = 6'b001110;
  localparam logic [5:0] OP_SLL = 6'b000100;
  localparam logic [5:0] OP_SRL = 6'b000101;
  localparam logic [5:0] OP_SRA = 6'b000110;
  localparam logic [5:0] OP_MUL = 6'b011000;
  localparam logic [5:0] OP_NOP = 6'b111111;

  localparam int ST_Z   = 0;
  localparam int ST_N   = 1;
  localparam int ST_C   = 2;
  localparam int ST_V   = 3;
  localparam int ST_ILL = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MULT = 1'b1
  } state_t;

  function automatic logic [4:0] pack_status(input logic ill, input logic v,
                                             input logic c, input logic n,
                                             input logic z);
    logic [4:0] s;
    s         = '0;
    s[ST_ILL] = ill;
    s[ST_V]   = v;
    s[ST_C]   = c;
    s[ST_N]   = n;
    s[ST_Z]   = z;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_if.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_if : operand handshake and result bus of alu_pipe
// Revision 1.0
// ------------------------------------------------------------------
interface alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [5:0]       opcode;
  logic             out_valid;
  logic [WIDTH-1:0] result_c;
  logic [4:0]       status;

  modport master (
    output in_valid, data_a, data_b, opcode,
    input  in_ready, out_valid, result_c, status
  );

  modport slave (
    input  in_valid, data_a, data_b, opcode,
    output in_ready, out_valid, result_c, status
  );
endinterface
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_mul_seq : iterative shift-add unsigned multiplier (low half)
// Revision 1.0
// ------------------------------------------------------------------
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start,
  input  wire logic             step,
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  output logic                  last,
  output logic [WIDTH-1:0]      product
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc_next;

  // product is this iteration's accumulator, so the final step can be captured directly
  assign acc_next = acc + (mplr[0] ? mcand : '0);
  assign product  = acc_next;
  assign last     = (cnt == SHW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (start) begin
      mcand <= a;
      mplr  <= b;
      acc   <= '0;
      cnt   <= '0;
    end else if (step) begin
      acc   <= acc_next;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_pipe : registered ALU with valid/ready input and sequential MUL
// Revision 1.0
// ------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input wire logic clk,
  input wire logic rst,
  alu_if.slave     bus
);
  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [4:0]       status;

  logic             transfer;
  logic             mul_start;
  logic             mul_step;
  logic             mul_last;
  logic [WIDTH-1:0] mul_prod;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res;
  logic             c_flag;
  logic             v_flag;
  logic             ill;
  logic             is_mul;
  logic             is_nop;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid;
  assign bus.result_c  = result;
  assign bus.status    = status;

  assign transfer  = bus.in_valid && (state == IDLE);
  assign mul_start = transfer && is_mul;
  assign mul_step  = (state == MULT);

  assign sum   = {1'b0, bus.data_a} + {1'b0, bus.data_b};
  assign diff  = {1'b0, bus.data_a} + {1'b0, ~bus.data_b} + (WIDTH+1)'(1);
  assign shamt = bus.data_b[SHW-1:0];

  always_comb begin
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    ill    = 1'b0;
    is_mul = 1'b0;
    is_nop = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        res    = sum[WIDTH-1:0];
        c_flag = sum[WIDTH];
        v_flag = (bus.data_a[WIDTH-1] == bus.data_b[WIDTH-1]) &&
                 (sum[WIDTH-1] != bus.data_a[WIDTH-1]);
      end
      OP_SUB: begin
        res    = diff[WIDTH-1:0];
        c_flag = diff[WIDTH];
        v_flag = (bus.data_a[WIDTH-1] != bus.data_b[WIDTH-1]) &&
                 (diff[WIDTH-1] != bus.data_a[WIDTH-1]);
      end
      OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(bus.data_a) < $signed(bus.data_b))};
      OP_AND: res = bus.data_a & bus.data_b;
      OP_OR:  res = bus.data_a | bus.data_b;
      OP_XOR: res = bus.data_a ^ bus.data_b;
      OP_SLL: res = bus.data_a << shamt;
      OP_SRL: res = bus.data_a >> shamt;
      OP_SRA: res = $signed(bus.data_a) >>> shamt;
      OP_MUL: is_mul = 1'b1;
      OP_NOP: is_nop = 1'b1;
      default: ill = 1'b1;
    endcase
  end

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .step    (mul_step),
    .a       (bus.data_a),
    .b       (bus.data_b),
    .last    (mul_last),
    .product (mul_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      status    <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            if (is_mul) begin
              state <= MULT;
            end else if (!is_nop) begin
              result    <= res;
              status    <= pack_status(ill, v_flag, c_flag, res[WIDTH-1], (res == '0));
              out_valid <= 1'b1;
            end
          end
        end
        MULT: begin
          if (mul_last) begin
            result    <= mul_prod;
            status    <= pack_status(1'b0, 1'b0, 1'b0, mul_prod[WIDTH-1], (mul_prod == '0));
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
